// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle core: phase encoding, NOP word and
// the opcode constants consumed by the control unit.
package riscv_pkg;

    typedef enum logic [2:0] {
        PH_FETCH     = 3'd0,
        PH_DECODE    = 3'd1,
        PH_EXECUTE   = 3'd2,
        PH_MEMORY    = 3'd3,
        PH_WRITEBACK = 3'd4
    } phase_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013; // ADDI x0, x0, 0
    localparam logic [2:0]  PHASE_LAST = 3'd4;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Clear the two low bits so a fetch address is always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_phase_fsm.sv
// Five-phase sequencer for the fetch stage. Holds in FETCH until the
// instruction memory acks, then steps through DECODE..WRITEBACK one cycle
// each. Produces the memory request, instr_valid and the two strobes the
// top level uses to load the instruction and program counter registers.
module fetch_phase_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       imem_ack,
    output logic [2:0] phase,
    output logic       instr_valid,
    output logic       imem_req,
    output logic       ack_accept,
    output logic       wb_edge
);

    localparam logic [2:0] ST_FETCH     = PH_FETCH;
    localparam logic [2:0] ST_DECODE    = PH_DECODE;
    localparam logic [2:0] ST_EXECUTE   = PH_EXECUTE;
    localparam logic [2:0] ST_MEMORY    = PH_MEMORY;
    localparam logic [2:0] ST_WRITEBACK = PH_WRITEBACK;

    logic [2:0] phase_q;
    logic [2:0] phase_d;

    // Request and strobes are decoded from state; reset masks them so an ack
    // arriving during a reset cycle is never accepted.
    always_comb begin
        imem_req    = (phase_q == ST_FETCH) && !rst;
        ack_accept  = imem_req && imem_ack;
        wb_edge     = (phase_q == PHASE_LAST) && !rst;
        instr_valid = (phase_q != ST_FETCH) && !rst;
        phase       = phase_q;
    end

    // Next phase: wait in FETCH for ack, otherwise advance unconditionally.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            ST_FETCH:     if (imem_ack) phase_d = ST_DECODE;
            ST_DECODE:    phase_d = ST_EXECUTE;
            ST_EXECUTE:   phase_d = ST_MEMORY;
            ST_MEMORY:    phase_d = ST_WRITEBACK;
            ST_WRITEBACK: phase_d = ST_FETCH;
            default:      phase_d = ST_FETCH;
        endcase
    end

    // Phase register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= ST_FETCH;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Multicycle instruction fetch stage: owns the PC and the instruction
// register feeding the control unit, sequenced by fetch_phase_fsm.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds a sticky misalign_err
// output flagging taken targets with nonzero low bits.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        PCSel,
    input  logic [31:0] alu_result,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [2:0]  phase,
    output logic        instr_valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    logic        ack_accept;
    logic        wb_edge;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;

    fetch_phase_fsm u_phase_fsm (
        .clk         (clk),
        .rst         (rst),
        .imem_ack    (imem_ack),
        .phase       (phase),
        .instr_valid (instr_valid),
        .imem_req    (imem_req),
        .ack_accept  (ack_accept),
        .wb_edge     (wb_edge)
    );

    // PC moves only when leaving WRITEBACK; instr loads only on an accepted ack.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (wb_edge) begin
            pc_d = PCSel ? align_word(alu_result) : pc_q + 32'd4;
        end
        if (ack_accept) begin
            instr_d = imem_rdata;
        end
    end

    // PC and instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;
    logic misalign_d;

    // Sticky until reset; the PC itself is still force-aligned above.
    always_comb begin
        misalign_d = misalign_q | (wb_edge && PCSel && (alu_result[1:0] != 2'b00));
    end

    // Misalignment flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. Two instances share all inputs: one with RESET_PC=0
// and one with RESET_PC=0xFFFFFFFC for the wrap case. Expectations come from
// a transaction-level model: one instruction = (waits) FETCH cycles + ack +
// four fixed phases, then the PC rule applied once.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RST_PC1 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        PCSel;
    logic [31:0] alu_result;

    logic        req0, req1, valid0, valid1;
    logic [31:0] addr0, addr1, instr0, instr1, pc0, pc1;
    logic [2:0]  phase0, phase1;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        mis0, mis1;
`endif

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] exp_pc0, exp_pc1, exp_instr;
    logic        exp_mis;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (req0),
        .imem_addr   (addr0),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PCSel       (PCSel),
        .alu_result  (alu_result),
        .instr       (instr0),
        .pc          (pc0),
        .phase       (phase0),
        .instr_valid (valid0)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_err(mis0)
`endif
    );

    fetch_unit #(.RESET_PC(RST_PC1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (req1),
        .imem_addr   (addr1),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PCSel       (PCSel),
        .alu_result  (alu_result),
        .instr       (instr1),
        .pc          (pc1),
        .phase       (phase1),
        .instr_valid (valid1)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_err(mis1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one full instruction sequence starting from FETCH (no checks).
    task automatic drive_seq(input int waits, input logic [31:0] rd, input logic sel,
                             input logic [31:0] tgt);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            tick();
        end
        imem_ack = 1'b1;
        imem_rdata = rd;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        PCSel = sel;
        alu_result = tgt;
        tick();
        PCSel = 1'b0;
        alu_result = $urandom;
        exp_instr = rd;
        exp_pc0 = sel ? (tgt & 32'hFFFF_FFFC) : exp_pc0 + 32'd4;
        exp_pc1 = sel ? (tgt & 32'hFFFF_FFFC) : exp_pc1 + 32'd4;
        if (sel && tgt[1:0] != 2'b00) exp_mis = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        tick();
        tick();
        exp_pc0 = 32'h0; exp_pc1 = RST_PC1; exp_instr = NOP; exp_mis = 1'b0;
        n_total++;
        if (req0 !== 1'b0) $display("FAIL reset_req_in_rst: got %b want 0", req0);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({req0, addr0, phase0, valid0} !== {1'b1, 32'h0, 3'd0, 1'b0})
            $display("FAIL reset_release: req/addr/phase/valid got %b/%h/%0d/%b want 1/0/0/0",
                     req0, addr0, phase0, valid0);
        else n_pass++;
        n_total++;
        if (instr0 !== NOP) $display("FAIL reset_instr: got %h want %h", instr0, NOP);
        else n_pass++;
        n_total++;
        if (pc1 !== RST_PC1) $display("FAIL reset_pc_alt: got %h want %h", pc1, RST_PC1);
        else n_pass++;
`ifdef FETCH_ALIGN_CHECK_EN
        n_total++;
        if (mis0 !== 1'b0) $display("FAIL reset_misalign: got %b want 0", mis0);
        else n_pass++;
`endif
    endtask

    task automatic test_zero_wait();
        imem_ack = 1'b1;
        imem_rdata = 32'h0050_0093;
        tick();
        imem_ack = 1'b0;
        n_total++;
        if ({phase0, instr0, valid0, req0} !== {3'd1, 32'h0050_0093, 1'b1, 1'b0})
            $display("FAIL zw_capture: phase/instr/valid/req got %0d/%h/%b/%b want 1/00500093/1/0",
                     phase0, instr0, valid0, req0);
        else n_pass++;
        for (int p = 2; p <= 4; p++) begin
            tick();
            n_total++;
            if (phase0 !== 3'(p)) $display("FAIL zw_phase: got %0d want %0d", phase0, p);
            else n_pass++;
        end
        PCSel = 1'b0;
        tick();
        exp_pc0 = 32'h4; exp_pc1 = exp_pc1 + 32'd4; exp_instr = 32'h0050_0093;
        n_total++;
        if ({req0, addr0, phase0} !== {1'b1, 32'h4, 3'd0})
            $display("FAIL zw_next_fetch: req/addr/phase got %b/%h/%0d want 1/4/0",
                     req0, addr0, phase0);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        int cycles = 0;
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = $urandom;
            tick();
            cycles++;
            n_total++;
            if ({phase0, addr0, instr0, req0} !== {3'd0, 32'h4, exp_instr, 1'b1})
                $display("FAIL ws_hold: phase/addr/instr/req got %0d/%h/%h/%b want 0/4/%h/1",
                         phase0, addr0, instr0, req0, exp_instr);
            else n_pass++;
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h0010_8113;
        tick();
        cycles++;
        imem_ack = 1'b0;
        while (phase0 != 3'd0 && cycles < 20) begin
            tick();
            cycles++;
        end
        exp_instr = 32'h0010_8113; exp_pc0 = 32'h8; exp_pc1 = exp_pc1 + 32'd4;
        n_total++;
        if (cycles !== 8) $display("FAIL ws_length: got %0d cycles want 8", cycles);
        else n_pass++;
        n_total++;
        if ({addr0, instr0} !== {32'h8, exp_instr})
            $display("FAIL ws_after: addr/instr got %h/%h want 8/%h", addr0, instr0, exp_instr);
        else n_pass++;
    endtask

    task automatic test_branch();
        drive_seq(1, 32'h0400_006F, 1'b1, 32'h0000_0040);
        n_total++;
        if ({pc0, pc1} !== {32'h40, 32'h40})
            $display("FAIL br_taken: pc0/pc1 got %h/%h want 40/40", pc0, pc1);
        else n_pass++;
        drive_seq(0, 32'h0020_0067, 1'b1, 32'h0000_0042);
        n_total++;
        if (pc0 !== 32'h40) $display("FAIL br_misaligned_pc: got %h want 40", pc0);
        else n_pass++;
`ifdef FETCH_ALIGN_CHECK_EN
        n_total++;
        if (mis0 !== 1'b1) $display("FAIL br_misalign_set: got %b want 1", mis0);
        else n_pass++;
`endif
        drive_seq(2, 32'h0000_0013, 1'b0, 32'h0000_0003);
        n_total++;
        if (pc0 !== 32'h44) $display("FAIL br_not_taken: got %h want 44", pc0);
        else n_pass++;
`ifdef FETCH_ALIGN_CHECK_EN
        n_total++;
        if (mis0 !== 1'b1) $display("FAIL br_misalign_sticky: got %b want 1", mis0);
        else n_pass++;
`endif
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_pc0 = 32'h0; exp_pc1 = RST_PC1; exp_instr = NOP; exp_mis = 1'b0;
        drive_seq(0, 32'h0000_0013, 1'b0, 32'h1234_5678);
        n_total++;
        if ({pc1, addr1, pc0} !== {32'h0, 32'h0, 32'h4})
            $display("FAIL wrap: pc1/addr1/pc0 got %h/%h/%h want 0/0/4", pc1, addr1, pc0);
        else n_pass++;
`ifdef FETCH_ALIGN_CHECK_EN
        n_total++;
        if (mis0 !== 1'b0) $display("FAIL wrap_misalign_cleared: got %b want 0", mis0);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        imem_ack = 1'b1;
        imem_rdata = 32'h0030_0193;
        tick();
        imem_ack = 1'b0;
        tick();
        n_total++;
        if (phase0 !== 3'd2) $display("FAIL mid_setup_phase: got %0d want 2", phase0);
        else n_pass++;
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        exp_pc0 = 32'h0; exp_pc1 = RST_PC1; exp_instr = NOP; exp_mis = 1'b0;
        n_total++;
        if ({pc0, pc1, phase0, instr0, req0, valid0} !== {32'h0, RST_PC1, 3'd0, NOP, 2'b00})
            $display("FAIL mid_reset: pc0/pc1/phase/instr/req/valid got %h/%h/%0d/%h/%b/%b",
                     pc0, pc1, phase0, instr0, req0, valid0);
        else n_pass++;
        tick();
        n_total++;
        if ({phase0, instr0} !== {3'd0, NOP})
            $display("FAIL mid_ack_discard: phase/instr got %0d/%h want 0/%h", phase0, instr0, NOP);
        else n_pass++;
        rst = 1'b0;
        imem_ack = 1'b0;
        #1;
        n_total++;
        if ({req0, addr0} !== {1'b1, 32'h0})
            $display("FAIL mid_release: req/addr got %b/%h want 1/0", req0, addr0);
        else n_pass++;
    endtask

    task automatic test_random();
        int w, cyc;
        logic [31:0] rd, tgt;
        logic sel;
        for (int k = 0; k < 40; k++) begin
            w = $urandom_range(0, 3);
            rd = $urandom;
            sel = 1'($urandom_range(0, 1));
            tgt = $urandom;
            cyc = 0;
            for (int i = 0; i < w; i++) begin
                imem_ack = 1'b0;
                imem_rdata = $urandom;
                tick();
                cyc++;
                n_total++;
                if ({phase0, addr0, instr0, req0, valid0} !== {3'd0, exp_pc0, exp_instr, 2'b10})
                    $display("FAIL rnd_wait[%0d]: phase/addr/instr got %0d/%h/%h want 0/%h/%h",
                             k, phase0, addr0, instr0, exp_pc0, exp_instr);
                else n_pass++;
            end
            imem_ack = 1'b1;
            imem_rdata = rd;
            tick();
            cyc++;
            exp_instr = rd;
            for (int p = 1; p <= 4; p++) begin
                n_total++;
                if ({phase0, instr0, valid0, req0} !== {3'(p), exp_instr, 2'b10})
                    $display("FAIL rnd_phase[%0d]: phase/instr/valid got %0d/%h/%b want %0d/%h/1",
                             k, phase0, instr0, valid0, p, exp_instr);
                else n_pass++;
                // Noise on inputs that must be ignored outside their sampling points.
                imem_ack = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
                PCSel = (p == 4) ? sel : 1'($urandom_range(0, 1));
                alu_result = (p == 4) ? tgt : $urandom;
                tick();
                cyc++;
            end
            exp_pc0 = sel ? {tgt[31:2], 2'b00} : exp_pc0 + 32'd4;
            exp_pc1 = sel ? {tgt[31:2], 2'b00} : exp_pc1 + 32'd4;
            if (sel && tgt[1:0] != 2'b00) exp_mis = 1'b1;
            n_total++;
            if ({phase0, pc0, pc1, instr0, req0} !== {3'd0, exp_pc0, exp_pc1, exp_instr, 1'b1})
                $display("FAIL rnd_wb[%0d]: phase/pc0/pc1/instr got %0d/%h/%h/%h want 0/%h/%h/%h",
                         k, phase0, pc0, pc1, instr0, exp_pc0, exp_pc1, exp_instr);
            else n_pass++;
            n_total++;
            if (cyc !== w + 5) $display("FAIL rnd_len[%0d]: got %0d want %0d", k, cyc, w + 5);
            else n_pass++;
`ifdef FETCH_ALIGN_CHECK_EN
            n_total++;
            if (mis1 !== exp_mis) $display("FAIL rnd_mis[%0d]: got %b want %b", k, mis1, exp_mis);
            else n_pass++;
`endif
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        PCSel = 1'b0;
        alu_result = 32'h0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
